multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the multi-cycle MIPS datapath: drives PC, IR, memory, register-file and ALU mux/enable
//  strobes through FETCH/DECODE/EXEC/MEM/WB. Uses the team ISA opcodes and ALUop encodings from
//  mips_defines.vh. Handshakes with a shared instruction/data memory via mem_ready. Counts retired instructions.
// PARAMETERS
//  CNT_W        32  width of instr_count
//  MEM_TIMEOUT  16  max wait cycles for mem_ready per access; 0 = wait forever
// PORTS
//  clk          in   1      sole clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  opcode       in   6      IR[31:26], valid from DECODE onward
//  zero         in   1      ALU zero flag (combinational, used in BRANCH)
//  mem_ready    in   1      memory completes current read/write this cycle
//  pc_write     out  1      load PC
//  pc_src       out  2      0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target
//  ir_write     out  1      load IR and MDR from memory read data
//  iord         out  1      memory address: 0=PC, 1=ALUOut
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  reg_write    out  1      register-file write enable
//  reg_dst      out  2      0=rt, 1=rd, 2=$31
//  mem_to_reg   out  2      0=ALUOut, 1=MDR, 2=PC
//  alu_src_a    out  1      0=PC, 1=rs
//  alu_src_b    out  2      0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op       out  3      ALUop_* code
//  state        out  4      current state encoding (debug)
//  instr_done   out  1      1-cycle pulse on last cycle of each retired instruction
//  instr_count  out  CNT_W  retired instruction count, wraps at 2^CNT_W
//  trap         out  1      sticky: illegal opcode or memory timeout
// BEHAVIOUR
//  Reset: state=FETCH(0), op_q=0, instr_count=0, trap=0, wait counter=0; all strobes forced 0 while rst=1.
//  Reset mid-instruction aborts it: no PC/reg/mem update, no count. Strobes decode from state/op_q;
//  unlisted strobes 0, alu_op=ALUop_ADD.
//  FETCH(0): mem_read=1,iord=0,alu_src_a=0,alu_src_b=1. Hold until mem_ready; that cycle ir_write=1,
//    pc_write=1,pc_src=0 -> DECODE.
//  DECODE(1): op_q<=opcode; alu_src_a=0,alu_src_b=3 (branch target into ALUOut). Next by opcode:
//    000000 R,000010 addi,000011 subi,000100 andi,000101 ori,000111 slti,100000 move -> EXEC;
//    001000 lw,010000 sw -> ADDR; 100011 beq,100111 bne -> BRANCH; 111000 j -> JUMP; 111001 jal -> JAL;
//    other -> TRAP.
//  EXEC(2): alu_src_a=1; R: alu_src_b=0,ALUop_RTYPE; addi/subi/andi/ori/slti: alu_src_b=2,
//    ALUop_ADD/SUB/AND/OR/LESS; move: alu_src_b=2, ALUop_OR (rs|0; imm field 0 by ISA). -> ALU_WB.
//  ALU_WB(3): reg_write=1,mem_to_reg=0, reg_dst=1 for R else 0; instr_done -> FETCH.
//  ADDR(4): alu_src_a=1,alu_src_b=2,ALUop_ADD -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD(5): mem_read=1,iord=1; on mem_ready -> LOAD_WB. (MDR captured by datapath on mem_ready.)
//  LOAD_WB(6): reg_write=1,reg_dst=0,mem_to_reg=1; instr_done -> FETCH.
//  MEM_WR(7): mem_write=1,iord=1; on mem_ready instr_done -> FETCH.
//  BRANCH(8): alu_src_a=1,alu_src_b=0,ALUop_SUB,pc_src=1; pc_write=zero (beq) / ~zero (bne);
//    instr_done -> FETCH.
//  JUMP(9): pc_write=1,pc_src=2; instr_done -> FETCH.
//  JAL(10): reg_write=1,reg_dst=2,mem_to_reg=2 (PC already +4), pc_write=1,pc_src=2; instr_done -> FETCH.
//  TRAP(15): all strobes 0, trap=1; stays until rst. instr_done never pulses here.
//  Wait counter clears on entry to FETCH/MEM_RD/MEM_WR; increments each cycle mem_ready=0. If MEM_TIMEOUT!=0
//    and counter reaches MEM_TIMEOUT with mem_ready=0 -> TRAP next cycle, strobes drop. mem_ready sampled in
//    the same cycle counter hits limit wins (access completes).
//  mem_ready outside FETCH/MEM_RD/MEM_WR is ignored. Unused encodings 11-14 -> TRAP.
//  instr_count increments on each instr_done cycle; wraps to 0 silently.
//  Latency (mem_ready immediate): R/imm/move 4 cycles, lw 5, sw 4, beq/bne/j/jal 3.
// TESTING
//  Reset then addi (op 000010), mem_ready=1 always -> states 0,1,2,3,0; ALU_WB reg_write=1,reg_dst=0;
//    instr_count=1 after 4 cycles.
//  lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read,iord=1 held 4 cycles, then LOAD_WB
//    mem_to_reg=1; total 8 cycles.
//  beq with zero=1 then zero=0 -> pc_write=1,pc_src=1 first; pc_write=0 second; bne inverts both.
//  jal -> JAL cycle: reg_write=1,reg_dst=2,mem_to_reg=2,pc_write=1,pc_src=2; instr_done pulse.
//  Opcode 111111, and separately mem_ready held 0 for 16 cycles in FETCH -> trap=1, all strobes 0
//    until rst; rst then state=0, trap=0.
//  rst asserted in MEM_WR -> mem_write drops same cycle, instr_count unchanged; CNT_W=2 with 5 retired -> 1.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memory (slave).
// Datapath status flows in; mux selects, enables and retirement status flow out.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [3:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             trap;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state,
           instr_done, instr_count, trap
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state,
           instr_done, instr_count, trap
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: 3-5 cycles per instruction with immediate mem_ready; stalls in
// FETCH/MEM_RD/MEM_WR while mem_ready is low, trapping after MEM_TIMEOUT wait cycles (0 = never).
module multicycle_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_controller_if.master ctl
);
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_LESS  = 3'd4;
  localparam logic [2:0] ALU_RTYPE = 3'd5;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_SUBI = 6'b000011;
  localparam logic [5:0] OP_ANDI = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b000101;
  localparam logic [5:0] OP_SLTI = 6'b000111;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_BEQ  = 6'b100011;
  localparam logic [5:0] OP_BNE  = 6'b100111;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111001;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC   = 4'd2,  S_ALU_WB = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_LOAD_WB = 4'd6, S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JAL    = 4'd10, S_TRAP   = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0] count_q;
  logic             trap_q;
  logic             waiting, timeout;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // A ready arriving on the last allowed wait cycle still completes the access.
  assign timeout = (MEM_TIMEOUT != 0) && waiting && !ctl.mem_ready &&
                   (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  assign ctl.state       = state_q;
  assign ctl.instr_count = count_q;
  assign ctl.trap        = trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      wait_q  <= '0;
      count_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= (state_d == S_TRAP);
      if (state_q == S_DECODE) op_q <= ctl.opcode;
      if (state_d != state_q) wait_q <= '0;
      else if (waiting && !ctl.mem_ready) wait_q <= wait_q + WAIT_W'(1);
      if (ctl.instr_done) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    ctl.pc_write   = 1'b0;
    ctl.pc_src     = 2'd0;
    ctl.ir_write   = 1'b0;
    ctl.iord       = 1'b0;
    ctl.mem_read   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.reg_write  = 1'b0;
    ctl.reg_dst    = 2'd0;
    ctl.mem_to_reg = 2'd0;
    ctl.alu_src_a  = 1'b0;
    ctl.alu_src_b  = 2'd0;
    ctl.alu_op     = ALU_ADD;
    ctl.instr_done = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = 2'd1;
          if (ctl.mem_ready) begin
            ctl.ir_write = 1'b1;
            ctl.pc_write = 1'b1;
            state_d      = S_DECODE;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_DECODE: begin
          ctl.alu_src_b = 2'd3;
          case (ctl.opcode)
            OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI, OP_MOVE: state_d = S_EXEC;
            OP_LW, OP_SW:   state_d = S_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            OP_JAL:         state_d = S_JAL;
            default:        state_d = S_TRAP;
          endcase
        end
        S_EXEC: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = 2'd2;
          case (op_q)
            OP_R: begin
              ctl.alu_src_b = 2'd0;
              ctl.alu_op    = ALU_RTYPE;
            end
            OP_SUBI: ctl.alu_op = ALU_SUB;
            OP_ANDI: ctl.alu_op = ALU_AND;
            OP_ORI, OP_MOVE: ctl.alu_op = ALU_OR;
            OP_SLTI: ctl.alu_op = ALU_LESS;
            default: ctl.alu_op = ALU_ADD;
          endcase
          state_d = S_ALU_WB;
        end
        S_ALU_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.reg_dst    = (op_q == OP_R) ? 2'd1 : 2'd0;
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_ADDR: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = 2'd2;
          state_d       = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          ctl.mem_read = 1'b1;
          ctl.iord     = 1'b1;
          if (ctl.mem_ready) state_d = S_LOAD_WB;
          else if (timeout) state_d = S_TRAP;
        end
        S_LOAD_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 2'd1;
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_MEM_WR: begin
          ctl.mem_write = 1'b1;
          ctl.iord      = 1'b1;
          if (ctl.mem_ready) begin
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_BRANCH: begin
          ctl.alu_src_a  = 1'b1;
          ctl.alu_op     = ALU_SUB;
          ctl.pc_src     = 2'd1;
          ctl.pc_write   = (op_q == OP_BNE) ? !ctl.zero : ctl.zero;
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_JUMP: begin
          ctl.pc_write   = 1'b1;
          ctl.pc_src     = 2'd2;
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_JAL: begin
          // PC already holds the return address from FETCH.
          ctl.reg_write  = 1'b1;
          ctl.reg_dst    = 2'd2;
          ctl.mem_to_reg = 2'd2;
          ctl.pc_write   = 1'b1;
          ctl.pc_src     = 2'd2;
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_TRAP;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: hand-computed strobe vectors per state, counter wrap
// with CNT_W=2, memory stall boundary, timeout/illegal-opcode trap and mid-instruction reset.
module tb_multicycle_controller;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_RTYPE = 3'd5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  multicycle_controller_if #(.CNT_W(2)) bus ();

  multicycle_controller #(.CNT_W(2), .MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  always #5 clk = ~clk;

  logic [17:0] stb;
  assign stb = {bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op};

  function automatic logic [17:0] pack(input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic io, input logic mrd, input logic mwr,
                                       input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic asa, input logic [1:0] asb, input logic [2:0] aop);
    return {pcw, pcs, irw, io, mrd, mwr, rw, rd, m2r, asa, asb, aop};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [17:0] exp_stb,
                      input logic done);
    #1;
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".strobes"}, 32'(stb), 32'(exp_stb));
    chk({tag, ".done"}, 32'(bus.instr_done), 32'(done));
    tick();
  endtask

  logic [17:0] f_rdy, f_wait, dec, ex_i, ex_r, wb_i, wb_r, mrd, lwb, mwr, br_t, br_n, jmp, jal;

  task automatic fetch_decode(input string tag);
    step({tag, ".fetch"}, 4'd0, f_rdy, 1'b0);
    step({tag, ".decode"}, 4'd1, dec, 1'b0);
  endtask

  initial begin
    f_rdy  = pack(1, 2'd0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd1, A_ADD);
    f_wait = pack(0, 2'd0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd1, A_ADD);
    dec    = pack(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd3, A_ADD);
    ex_i   = pack(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, A_ADD);
    ex_r   = pack(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, A_RTYPE);
    wb_i   = pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 2'd0, A_ADD);
    wb_r   = pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, A_ADD);
    mrd    = pack(0, 2'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, A_ADD);
    lwb    = pack(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 2'd0, A_ADD);
    mwr    = pack(0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, A_ADD);
    br_t   = pack(1, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, A_SUB);
    br_n   = pack(0, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, A_SUB);
    jmp    = pack(1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, A_ADD);
    jal    = pack(1, 2'd2, 0, 0, 0, 0, 1, 2'd2, 2'd2, 0, 2'd0, A_ADD);

    rst = 1'b1;
    bus.opcode = 6'b000010;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    // Still in reset: FETCH would request memory, but every strobe must be held low.
    chk("rst.strobes", 32'(stb), 32'd0);
    chk("rst.done", 32'(bus.instr_done), 32'd0);
    chk("rst.state", 32'(bus.state), 32'd0);
    chk("rst.count", 32'(bus.instr_count), 32'd0);
    chk("rst.trap", 32'(bus.trap), 32'd0);
    rst = 1'b0;

    fetch_decode("addi");
    step("addi.exec", 4'd2, ex_i, 1'b0);
    step("addi.wb", 4'd3, wb_i, 1'b1);
    chk("addi.count", 32'(bus.instr_count), 32'd1);

    bus.opcode = 6'b001000;
    fetch_decode("lw");
    step("lw.addr", 4'd4, ex_i, 1'b0);
    bus.mem_ready = 1'b0;
    repeat (3) step("lw.memrd_wait", 4'd5, mrd, 1'b0);
    bus.mem_ready = 1'b1;
    step("lw.memrd_rdy", 4'd5, mrd, 1'b0);
    step("lw.wb", 4'd6, lwb, 1'b1);
    chk("lw.count", 32'(bus.instr_count), 32'd2);

    bus.opcode = 6'b000000;
    fetch_decode("r");
    step("r.exec", 4'd2, ex_r, 1'b0);
    step("r.wb", 4'd3, wb_r, 1'b1);
    chk("r.count", 32'(bus.instr_count), 32'd3);

    bus.opcode = 6'b100011;
    bus.zero = 1'b1;
    fetch_decode("beq1");
    step("beq1.branch", 4'd8, br_t, 1'b1);
    chk("beq1.count_wrap", 32'(bus.instr_count), 32'd0);
    bus.zero = 1'b0;
    fetch_decode("beq0");
    step("beq0.branch", 4'd8, br_n, 1'b1);
    chk("beq0.count", 32'(bus.instr_count), 32'd1);

    bus.opcode = 6'b100111;
    bus.zero = 1'b1;
    fetch_decode("bne1");
    step("bne1.branch", 4'd8, br_n, 1'b1);
    chk("bne1.count", 32'(bus.instr_count), 32'd2);
    bus.zero = 1'b0;
    fetch_decode("bne0");
    step("bne0.branch", 4'd8, br_t, 1'b1);
    chk("bne0.count", 32'(bus.instr_count), 32'd3);

    bus.opcode = 6'b111001;
    fetch_decode("jal");
    step("jal.jal", 4'd10, jal, 1'b1);
    chk("jal.count", 32'(bus.instr_count), 32'd0);

    bus.opcode = 6'b111000;
    fetch_decode("j");
    step("j.jump", 4'd9, jmp, 1'b1);
    chk("j.count", 32'(bus.instr_count), 32'd1);

    bus.opcode = 6'b010000;
    fetch_decode("sw");
    step("sw.addr", 4'd4, ex_i, 1'b0);
    step("sw.memwr", 4'd7, mwr, 1'b1);
    chk("sw.count", 32'(bus.instr_count), 32'd2);

    fetch_decode("swabort");
    step("swabort.addr", 4'd4, ex_i, 1'b0);
    bus.mem_ready = 1'b0;
    step("swabort.memwr", 4'd7, mwr, 1'b0);
    rst = 1'b1;
    #1;
    chk("swabort.strobes", 32'(stb), 32'd0);
    chk("swabort.done", 32'(bus.instr_done), 32'd0);
    chk("swabort.count", 32'(bus.instr_count), 32'd2);
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    chk("swabort.state", 32'(bus.state), 32'd0);
    chk("swabort.count_rst", 32'(bus.instr_count), 32'd0);

    bus.opcode = 6'b111111;
    fetch_decode("illegal");
    step("illegal.trap", 4'd15, 18'd0, 1'b0);
    chk("illegal.trap_flag", 32'(bus.trap), 32'd1);
    step("illegal.trap_hold", 4'd15, 18'd0, 1'b0);
    chk("illegal.count", 32'(bus.instr_count), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("illegal.rst_state", 32'(bus.state), 32'd0);
    chk("illegal.rst_trap", 32'(bus.trap), 32'd0);

    // Ready on the 16th wait cycle is the latest arrival that still completes the fetch.
    bus.opcode = 6'b111000;
    bus.mem_ready = 1'b0;
    repeat (15) step("edge.wait", 4'd0, f_wait, 1'b0);
    bus.mem_ready = 1'b1;
    step("edge.fetch", 4'd0, f_rdy, 1'b0);
    step("edge.decode", 4'd1, dec, 1'b0);
    step("edge.jump", 4'd9, jmp, 1'b1);
    chk("edge.count", 32'(bus.instr_count), 32'd1);
    chk("edge.trap", 32'(bus.trap), 32'd0);

    bus.mem_ready = 1'b0;
    repeat (16) step("tmo.wait", 4'd0, f_wait, 1'b0);
    step("tmo.trap", 4'd15, 18'd0, 1'b0);
    chk("tmo.trap_flag", 32'(bus.trap), 32'd1);
    bus.mem_ready = 1'b1;
    step("tmo.trap_hold", 4'd15, 18'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tmo.rst_state", 32'(bus.state), 32'd0);
    chk("tmo.rst_trap", 32'(bus.trap), 32'd0);
    chk("tmo.rst_count", 32'(bus.instr_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
